// File: rtl/button_event_fifo.sv
// rtl/button_event_fifo.sv - FWFT event FIFO for button edge pulses
// Drops events on overflow and tallies them in a saturating counter.
module button_event_fifo #(
  parameter int width = 4,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [width-1:0]         in_pulse,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic [7:0]               dropped,
  input  logic                     clear_dropped
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       dropped_q, dropped_d;

  logic wr_req;
  logic wr_acc;
  logic rd_acc;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // A write into a full FIFO is only legal when the head leaves this cycle.
  assign wr_req = |in_pulse;
  assign wr_acc = wr_req && (!full || rd_en);
  assign rd_acc = rd_en && !empty;
  assign drop   = wr_req && full && !rd_en;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end

    if (clear_dropped) begin
      dropped_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= in_pulse;
    end
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_button_event_fifo.sv
// tb/tb_button_event_fifo.sv - self-checking bench for button_event_fifo
// Directed plan steps followed by random traffic against a queue model.
module tb_button_event_fifo;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_pulse = '0;
  logic         rd_en = 1'b0;
  logic         clear_dropped = 1'b0;
  logic [W-1:0] rd_data;
  logic         empty;
  logic         full;
  logic [$clog2(D):0] count;
  logic [7:0]   dropped;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq[$];
  int           mdropped = 0;

  button_event_fifo #(.width(W), .depth(D)) dut (
    .clk(clk),
    .rst(rst),
    .in_pulse(in_pulse),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .dropped(dropped),
    .clear_dropped(clear_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    int head;
    n = mq.size();
    head = (n > 0) ? int'(mq[0]) : 0;
    chk({tag, ".count"},   int'(count),   n);
    chk({tag, ".empty"},   int'(empty),   (n == 0) ? 1 : 0);
    chk({tag, ".full"},    int'(full),    (n == D) ? 1 : 0);
    chk({tag, ".rd_data"}, int'(rd_data), head);
    chk({tag, ".dropped"}, int'(dropped), mdropped);
  endtask

  // Model: occupancy rules applied to a queue, evaluated on pre-edge state.
  task automatic cycle(input string tag, input logic [W-1:0] p, input logic rd,
                       input logic clr, input logic r);
    bit was_full;
    bit do_wr;
    bit do_rd;
    bit do_drop;
    in_pulse = p;
    rd_en = rd;
    clear_dropped = clr;
    rst = r;
    was_full = (mq.size() == D);
    do_wr   = (p != 0) && (!was_full || rd);
    do_rd   = rd && (mq.size() != 0);
    do_drop = (p != 0) && was_full && !rd;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mdropped = 0;
    end else begin
      if (do_rd) void'(mq.pop_front());
      if (do_wr) mq.push_back(p);
      if (clr) mdropped = do_drop ? 1 : 0;
      else if (do_drop && mdropped < 255) mdropped++;
    end
    #1;
    in_pulse = '0;
    rd_en = 1'b0;
    clear_dropped = 1'b0;
    rst = 1'b0;
    check_all(tag);
  endtask

  initial begin
    @(negedge clk);
    cycle("reset", '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle("idle", '0, 1'b0, 1'b0, 1'b0);

    cycle("ev0010", 4'b0010, 1'b0, 1'b0, 1'b0);
    cycle("gap", '0, 1'b0, 1'b0, 1'b0);
    cycle("gap", '0, 1'b0, 1'b0, 1'b0);
    cycle("ev1001", 4'b1001, 1'b0, 1'b0, 1'b0);
    cycle("pop1", '0, 1'b1, 1'b0, 1'b0);
    chk("pop1.head", int'(rd_data), 9);
    cycle("pop2", '0, 1'b1, 1'b0, 1'b0);
    cycle("pop_empty", '0, 1'b1, 1'b0, 1'b0);

    for (int i = 1; i <= 10; i++) cycle("fill10", W'(i), 1'b0, 1'b0, 1'b0);
    chk("fill10.dropped", int'(dropped), 2);
    for (int i = 0; i < 8; i++) cycle("drain", '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) cycle("refill", W'(i + 3), 1'b0, 1'b0, 1'b0);
    cycle("full_wr_rd", 4'b0100, 1'b1, 1'b0, 1'b0);
    chk("full_wr_rd.count", int'(count), 8);
    for (int i = 0; i < 7; i++) cycle("drain2", '0, 1'b1, 1'b0, 1'b0);
    chk("last_entry", int'(rd_data), 4);
    cycle("drain2", '0, 1'b1, 1'b0, 1'b0);
    cycle("empty_wr_rd", 4'b0110, 1'b1, 1'b0, 1'b0);
    chk("empty_wr_rd.count", int'(count), 1);

    for (int i = 0; i < 7; i++) cycle("fill", W'(i + 1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle("drops", 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("sat.dropped", int'(dropped), 255);
    cycle("clr_drop", 4'b0001, 1'b0, 1'b1, 1'b0);
    chk("clr_drop.dropped", int'(dropped), 1);
    cycle("clr_alone", '0, 1'b0, 1'b1, 1'b0);
    chk("clr_alone.dropped", int'(dropped), 0);

    cycle("drop1", 4'b0011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("to5", '0, 1'b1, 1'b0, 1'b0);
    chk("five.count", int'(count), 5);
    cycle("rst_mid", 4'b1010, 1'b1, 1'b1, 1'b1);
    chk("rst_mid.count", int'(count), 0);
    chk("rst_mid.rd_data", int'(rd_data), 0);

    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] p;
      logic rd;
      logic clr;
      logic r;
      p   = ($urandom_range(0, 2) != 0) ? W'($urandom) : '0;
      rd  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 40) == 0);
      r   = ($urandom_range(0, 150) == 0);
      cycle("rand", p, rd, clr, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
